// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle MIPS main control.
// Holds the FSM state encoding, opcode/funct field values, ALU operation
// codes and the datapath mux select values used by the control FSM.
package controle_pkg;

    // State encoding doubles as the debug value on estado.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDIEX   = 4'd11,
        S_ADDIWB   = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    // Opcode field values (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type funct field values (instr[5:0]).
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes driven on aluControlOut.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU B input selects.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC selects.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/controle_multiciclo_alu_controle.sv
// R-type funct decoder for the multicycle control.
// Ports:
//   i_funct        instr[5:0]
//   o_alu_control  ALU operation code (0000 when funct is unsupported)
//   o_valid        1 when funct is one of AND/OR/ADD/SUB/SLT
import controle_pkg::*;

module alu_controle #(
    parameter int OPW = 6,
    parameter int ACW = 4
) (
    input  logic [OPW-1:0] i_funct,
    output logic [ACW-1:0] o_alu_control,
    output logic           o_valid
);

    always_comb begin
        o_alu_control = ACW'(ALU_AND);
        o_valid       = 1'b1;
        case (i_funct)
            OPW'(FN_AND): o_alu_control = ACW'(ALU_AND);
            OPW'(FN_OR):  o_alu_control = ACW'(ALU_OR);
            OPW'(FN_ADD): o_alu_control = ACW'(ALU_ADD);
            OPW'(FN_SUB): o_alu_control = ACW'(ALU_SUB);
            OPW'(FN_SLT): o_alu_control = ACW'(ALU_SLT);
            default:      o_valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control FSM (Moore).
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// enable and mux select. All outputs decode from the state register except
// pcEn, which combines the branch state with the live ALU zero flag.
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   opcode, funct          instruction fields from the IR
//   zero                   ALU zero flag (used only in BRANCH)
//   pcEn .. aluControlOut  datapath enables and selects
//   illegal                one-cycle pulse on an unsupported instruction
//   estado                 current state, debug only
import controle_pkg::*;

module controle_multiciclo #(
    parameter int OPW = 6,
    parameter int ACW = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    output logic           pcEn,
    output logic           iorD,
    output logic           memRead,
    output logic           memWrite,
    output logic           irWrite,
    output logic           regDst,
    output logic           memToReg,
    output logic           regWrite,
    output logic           aluSrcA,
    output logic [1:0]     aluSrcB,
    output logic [1:0]     pcSource,
    output logic [ACW-1:0] aluControlOut,
    output logic           illegal,
    output logic [3:0]     estado
);

    state_t         r_state;
    state_t         w_next;
    logic           w_pc_write;
    logic           w_branch;
    logic [ACW-1:0] w_funct_alu;
    logic           w_funct_ok;

    alu_controle #(.OPW(OPW), .ACW(ACW)) u_alu_controle (
        .i_funct       (funct),
        .o_alu_control (w_funct_alu),
        .o_valid       (w_funct_ok)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic. The IR is not reloaded between DECODE and the end of
    // the instruction, so opcode is still valid in MEMADR for the lw/sw split.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPW'(OP_RTYPE):         w_next = S_EXECUTE;
                    OPW'(OP_LW), OPW'(OP_SW): w_next = S_MEMADR;
                    OPW'(OP_BEQ):           w_next = S_BRANCH;
                    OPW'(OP_J):             w_next = S_JUMP;
                    OPW'(OP_ADDI):          w_next = S_ADDIEX;
                    default:                w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (opcode == OPW'(OP_SW)) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECUTE:  w_next = w_funct_ok ? S_ALUWB : S_ILLEGAL;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_ADDIEX:   w_next = S_ADDIWB;
            S_ADDIWB:   w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_FETCH;
            default:    w_next = S_IDLE;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        iorD          = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        irWrite       = 1'b0;
        regDst        = 1'b0;
        memToReg      = 1'b0;
        regWrite      = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = SRCB_REG;
        pcSource      = PCSRC_ALU;
        aluControlOut = ACW'(ALU_AND);
        illegal       = 1'b0;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead       = 1'b1;
                irWrite       = 1'b1;
                aluSrcB       = SRCB_FOUR;
                aluControlOut = ACW'(ALU_ADD);
                w_pc_write    = 1'b1;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                aluSrcB       = SRCB_IMM_SH2;
                aluControlOut = ACW'(ALU_ADD);
            end
            S_MEMADR, S_ADDIEX: begin
                aluSrcA       = 1'b1;
                aluSrcB       = SRCB_IMM;
                aluControlOut = ACW'(ALU_ADD);
            end
            S_MEMREAD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA       = 1'b1;
                aluControlOut = w_funct_alu;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA       = 1'b1;
                aluControlOut = ACW'(ALU_SUB);
                pcSource      = PCSRC_ALUOUT;
                w_branch      = 1'b1;
            end
            S_JUMP: begin
                pcSource   = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            S_ADDIWB:  regWrite = 1'b1;
            S_ILLEGAL: illegal  = 1'b1;
            default: ;
        endcase
    end

    assign pcEn   = w_pc_write | (w_branch & zero);
    assign estado = r_state;

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite;
    logic       aluSrcA, illegal;
    logic [1:0] aluSrcB, pcSource;
    logic [3:0] aluControlOut, estado;

    int n_checks = 0;
    int n_errors = 0;

    controle_multiciclo dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .pcEn          (pcEn),
        .iorD          (iorD),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .irWrite       (irWrite),
        .regDst        (regDst),
        .memToReg      (memToReg),
        .regWrite      (regWrite),
        .aluSrcA       (aluSrcA),
        .aluSrcB       (aluSrcB),
        .pcSource      (pcSource),
        .aluControlOut (aluControlOut),
        .illegal       (illegal),
        .estado        (estado)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [21:0] all_outs();
        return {pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite,
                aluSrcA, aluSrcB, pcSource, aluControlOut, illegal, estado};
    endfunction

    // Safety invariants sampled away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("inv_rd_wr", {31'd0, memRead & memWrite}, 32'd0);
            check("inv_rw_mw", {31'd0, regWrite & memWrite}, 32'd0);
        end
    end

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100010;
        zero   = 1'b0;

        // Reset held 3 cycles, outputs all zero throughout.
        repeat (3) begin
            tick();
            check("rst_outs", {10'd0, all_outs()}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        check("idle_outs", {10'd0, all_outs()}, 32'd0);

        // FETCH
        tick();
        check("fetch_st", estado, 1);
        check("fetch_mr", memRead, 1);
        check("fetch_ir", irWrite, 1);
        check("fetch_pcen", pcEn, 1);
        check("fetch_alu", aluControlOut, 4'b0010);
        check("fetch_srcb", aluSrcB, 2'b01);

        // R-type SUB: 1,2,7,8,1
        tick(); check("r_dec_st", estado, 2);
        check("r_dec_srcb", aluSrcB, 2'b11);
        check("r_dec_rw", regWrite, 0);
        tick(); check("r_ex_st", estado, 7);
        check("r_ex_alu", aluControlOut, 4'b0110);
        check("r_ex_srca", aluSrcA, 1);
        check("r_ex_rw", regWrite, 0);
        tick(); check("r_wb_st", estado, 8);
        check("r_wb_rw", regWrite, 1);
        check("r_wb_rd", regDst, 1);
        tick(); check("r_back_st", estado, 1);
        check("r_back_rw", regWrite, 0);

        // lw: 1,2,3,4,5,1
        opcode = 6'b100011;
        tick(); check("lw_dec_st", estado, 2);
        tick(); check("lw_adr_st", estado, 3);
        check("lw_adr_srcb", aluSrcB, 2'b10);
        tick(); check("lw_rd_st", estado, 4);
        check("lw_rd_iord", iorD, 1);
        check("lw_rd_mr", memRead, 1);
        tick(); check("lw_wb_st", estado, 5);
        check("lw_wb_m2r", memToReg, 1);
        check("lw_wb_rw", regWrite, 1);
        check("lw_wb_rd", regDst, 0);
        tick(); check("lw_back_st", estado, 1);

        // sw: 1,2,3,6,1 with one memWrite cycle
        opcode = 6'b101011;
        tick(); check("sw_dec_st", estado, 2);
        tick(); check("sw_adr_st", estado, 3);
        check("sw_adr_mw", memWrite, 0);
        tick(); check("sw_wr_st", estado, 6);
        check("sw_wr_mw", memWrite, 1);
        check("sw_wr_iord", iorD, 1);
        tick(); check("sw_back_st", estado, 1);
        check("sw_back_mw", memWrite, 0);

        // beq taken
        opcode = 6'b000100;
        zero   = 1'b1;
        tick(); check("beq1_dec_pcen", pcEn, 0);
        tick(); check("beq1_st", estado, 9);
        check("beq1_pcen", pcEn, 1);
        check("beq1_pcsrc", pcSource, 2'b01);
        check("beq1_alu", aluControlOut, 4'b0110);
        tick(); check("beq1_back_st", estado, 1);

        // beq not taken
        zero = 1'b0;
        tick(); check("beq0_dec_st", estado, 2);
        tick(); check("beq0_st", estado, 9);
        check("beq0_pcen", pcEn, 0);
        tick(); check("beq0_back_st", estado, 1);

        // j
        opcode = 6'b000010;
        tick(); check("j_dec_st", estado, 2);
        tick(); check("j_st", estado, 10);
        check("j_pcen", pcEn, 1);
        check("j_pcsrc", pcSource, 2'b10);
        tick(); check("j_back_st", estado, 1);

        // addi: 1,2,11,12,1
        opcode = 6'b001000;
        tick(); check("addi_dec_st", estado, 2);
        tick(); check("addi_ex_st", estado, 11);
        check("addi_ex_srca", aluSrcA, 1);
        check("addi_ex_srcb", aluSrcB, 2'b10);
        check("addi_ex_alu", aluControlOut, 4'b0010);
        tick(); check("addi_wb_st", estado, 12);
        check("addi_wb_rw", regWrite, 1);
        check("addi_wb_rd", regDst, 0);
        tick(); check("addi_back_st", estado, 1);

        // Illegal opcode
        opcode = 6'b111111;
        tick(); check("ill_dec_st", estado, 2);
        check("ill_dec_pulse", illegal, 0);
        tick(); check("ill_st", estado, 13);
        check("ill_pulse", illegal, 1);
        check("ill_rw", regWrite, 0);
        check("ill_mw", memWrite, 0);
        check("ill_pcen", pcEn, 0);
        tick(); check("ill_back_st", estado, 1);
        check("ill_back_pulse", illegal, 0);

        // Illegal funct
        opcode = 6'b000000;
        funct  = 6'b000000;
        tick(); check("ilf_dec_st", estado, 2);
        tick(); check("ilf_ex_st", estado, 7);
        check("ilf_ex_alu", aluControlOut, 4'b0000);
        tick(); check("ilf_st", estado, 13);
        check("ilf_pulse", illegal, 1);
        check("ilf_rw", regWrite, 0);
        tick(); check("ilf_back_st", estado, 1);
        check("ilf_back_pulse", illegal, 0);

        // Async reset in MEMWB
        opcode = 6'b100011;
        funct  = 6'b100000;
        tick(); tick(); tick(); tick();
        check("ar_pre_st", estado, 5);
        check("ar_pre_rw", regWrite, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_rw", regWrite, 0);
        check("ar_st", estado, 0);
        check("ar_outs", {10'd0, all_outs()}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick(); check("ar_fetch_st", estado, 1);
        check("ar_fetch_mr", memRead, 1);
        tick(); check("ar_dec_st", estado, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
